// File: rtl/mat_mem_pkg.sv
// Shared definitions for the matrix memory, its port controller and the multiplier.
package mat_mem_pkg;

  // Default matrix geometry shared by the memory, controller and multiplier
  localparam int unsigned MAT_ROW    = 2;
  localparam int unsigned MAT_COLUMN = 2;
  localparam int unsigned MAT_SIZE   = 8;

  // Memory address bus width
  localparam int unsigned MEM_AW = 32;

  // Port controller state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RD_REQ = 2'd2,
    OUT    = 2'd3
  } port_state_t;

endpackage

// File: rtl/mat_mem_port_ctrl.sv
// Streams N elements into the matrix memory row-major, then reads them back
// out onto a valid/ready stream with a read strobe that toggles every element.
module mat_mem_port_ctrl
  import mat_mem_pkg::*;
#(
  parameter int unsigned ROW    = MAT_ROW,
  parameter int unsigned COLUMN = MAT_COLUMN,
  parameter int unsigned SIZE   = MAT_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              dump_start,
  output logic              busy,
  input  logic              in_valid,
  input  logic [SIZE-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [SIZE-1:0]   out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_write_address,
  output logic [SIZE-1:0]   mem_write_value,
  output logic              mem_read,
  output logic [MEM_AW-1:0] mem_read_address,
  input  logic [SIZE-1:0]   mem_data
);

  localparam int unsigned N  = ROW * COLUMN;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  port_state_t state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic              busy_n, in_ready_n, out_valid_n, out_last_n;
  logic              mem_write_n, mem_read_n;
  logic [SIZE-1:0]   out_data_n, mem_write_value_n;
  logic [MEM_AW-1:0] mem_write_address_n, mem_read_address_n;

  // State, index and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      busy              <= 1'b0;
      in_ready          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_last          <= 1'b0;
      mem_write         <= 1'b0;
      mem_write_address <= '0;
      mem_write_value   <= '0;
      mem_read          <= 1'b0;
      mem_read_address  <= '0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      busy              <= busy_n;
      in_ready          <= in_ready_n;
      out_valid         <= out_valid_n;
      out_data          <= out_data_n;
      out_last          <= out_last_n;
      mem_write         <= mem_write_n;
      mem_write_address <= mem_write_address_n;
      mem_write_value   <= mem_write_value_n;
      mem_read          <= mem_read_n;
      mem_read_address  <= mem_read_address_n;
    end
  end

  // Next state, index and output values; flags follow the state being entered
  always_comb begin
    state_n             = state;
    idx_n               = idx;
    mem_write_n         = 1'b0;
    mem_write_address_n = mem_write_address;
    mem_write_value_n   = mem_write_value;
    mem_read_address_n  = mem_read_address;
    out_data_n          = out_data;

    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_n = LOAD;
          idx_n   = '0;
        end else if (dump_start) begin
          state_n = RD_REQ;
          idx_n   = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          mem_write_n         = 1'b1;
          mem_write_address_n = MEM_AW'(idx);
          mem_write_value_n   = in_data;
          if (idx == LAST) state_n = IDLE;
          else             idx_n   = idx + IW'(1);
        end
      end
      RD_REQ: begin
        out_data_n = mem_data;
        state_n    = OUT;
      end
      OUT: begin
        if (out_valid && out_ready) begin
          if (idx == LAST) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = RD_REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n      = (state_n != IDLE);
    in_ready_n  = (state_n == LOAD);
    out_valid_n = (state_n == OUT);
    out_last_n  = (state_n == OUT) && (idx_n == LAST);
    mem_read_n  = (state_n == RD_REQ);
    if (state_n == RD_REQ) mem_read_address_n = MEM_AW'(idx_n);
  end

endmodule

// File: tb/tb_mat_mem_port_ctrl.sv
// Directed bench for mat_mem_port_ctrl with a small matrix memory model on the same clk/rst.
module tb_mat_mem_port_ctrl;

  localparam int unsigned SIZE = 8;
  localparam int unsigned N    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_start, dump_start, busy;
  logic            in_valid, in_ready;
  logic [SIZE-1:0] in_data;
  logic            out_valid, out_last, out_ready;
  logic [SIZE-1:0] out_data;
  logic            mem_write, mem_read;
  logic [31:0]     mem_write_address, mem_read_address;
  logic [SIZE-1:0] mem_write_value, mem_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mat_mem_port_ctrl #(.ROW(2), .COLUMN(2), .SIZE(SIZE)) dut (
    .clk               (clk),
    .rst               (rst),
    .load_start        (load_start),
    .dump_start        (dump_start),
    .busy              (busy),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_last          (out_last),
    .out_ready         (out_ready),
    .mem_write         (mem_write),
    .mem_write_address (mem_write_address),
    .mem_write_value   (mem_write_value),
    .mem_read          (mem_read),
    .mem_read_address  (mem_read_address),
    .mem_data          (mem_data)
  );

  // Matrix memory model: cleared by the shared reset, combinational read
  logic [SIZE-1:0] mem [N];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_write_address[1:0]] <= mem_write_value;
    end
  end
  assign mem_data = mem[mem_read_address[1:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " out_last"}, out_last, 0);
    check({tag, " mem_write"}, mem_write, 0);
    check({tag, " mem_read"}, mem_read, 0);
    check({tag, " wr_addr"}, mem_write_address, 0);
    check({tag, " rd_addr"}, mem_read_address, 0);
  endtask

  // Full load of base, base+1, ... with continuous in_valid
  task automatic run_load(input int base);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load in_ready", in_ready, 1);
    check("load busy", busy, 1);
    in_valid = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      in_data = SIZE'(base + i);
      tick();
      check("load mem_write", mem_write, 1);
      check("load wr_addr", mem_write_address, 32'(i));
      check("load wr_value", mem_write_value, 32'(base + i));
    end
    in_valid = 1'b0;
    check("load end busy", busy, 0);
    check("load end in_ready", in_ready, 0);
  endtask

  // Full dump with out_ready high; expected element i is base + step*i
  task automatic run_dump(input int base, input int step);
    dump_start = 1'b1;
    out_ready  = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      check("dump mem_read hi", mem_read, 1);
      check("dump rd_addr", mem_read_address, 32'(i));
      check("dump out_valid lo", out_valid, 0);
      tick();
      check("dump mem_read lo", mem_read, 0);
      check("dump out_valid", out_valid, 1);
      check("dump out_data", out_data, 32'(base + step * i));
      check("dump out_last", out_last, (i == int'(N) - 1) ? 1 : 0);
      tick();
    end
    check("dump end busy", busy, 0);
    check("dump end out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b1; dump_start = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with start pulses held high
    tick();
    tick();
    check_all_zero("reset");
    load_start = 1'b0; dump_start = 1'b0; rst = 1'b0;
    tick();
    check_all_zero("post reset");

    // Basic load and dump
    run_load(5);
    tick();
    check("idle mem_write", mem_write, 0);
    run_dump(5, 1);

    // Stall on element at index 1
    dump_start = 1'b1;
    out_ready  = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    check("stall el0", out_data, 5);
    tick();
    check("stall rd idx1", mem_read_address, 1);
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("stall out_valid", out_valid, 1);
      check("stall out_data", out_data, 6);
      check("stall mem_read", mem_read, 0);
      tick();
    end
    check("stall still held", out_data, 6);
    out_ready = 1'b1;
    tick();
    check("stall release mem_read", mem_read, 1);
    check("stall release addr", mem_read_address, 2);
    begin
      int budget = 20;
      while (busy && budget > 0) begin
        tick();
        budget--;
      end
      check("stall drain timeout", busy, 0);
    end

    // Simultaneous starts, ignored mid-load dump, dump in the final strobe cycle
    load_start = 1'b1; dump_start = 1'b1;
    tick();
    load_start = 1'b0; dump_start = 1'b0;
    check("both in_ready", in_ready, 1);
    check("both mem_read", mem_read, 0);
    in_valid = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      in_data    = SIZE'(9 + i);
      dump_start = (i == 1);
      tick();
      check("mid mem_write", mem_write, 1);
      check("mid wr_addr", mem_write_address, 32'(i));
      check("mid mem_read", mem_read, 0);
    end
    in_valid   = 1'b0;
    dump_start = 1'b0;
    check("mid end busy", busy, 0);
    run_dump(9, 1);

    // Reset after two load handshakes
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd20;
    tick();
    in_data = 8'd21;
    tick();
    check("abort wr_addr", mem_write_address, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    run_dump(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mat_mem_port_ctrl.md
# mat_mem_port_ctrl

Initiator-side controller for the matrix multiplier's element memory. It converts a valid/ready element stream into row-major write pulses to the memory, then reads the matrix back out onto a valid/ready output stream. It owns the memory's write, read and address pins and sits between the host or datapath streams and one matrix memory instance.

## Interface
Parameters:
- ROW, 2, matrix rows
- COLUMN, 2, matrix columns
- SIZE, 8, element width in bits
- N (local), ROW*COLUMN, element count; IW (local) = max(1, $clog2(N)), index width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- load_start  in  1  pulse; begin load of N elements
- dump_start  in  1  pulse; begin readback of N elements
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  input element valid
- in_data  in  SIZE  input element
- in_ready  out  1  high in LOAD
- out_valid  out  1  output element valid
- out_data  out  SIZE  output element, registered
- out_last  out  1  out_valid on element N-1
- out_ready  in  1  downstream accepts
- mem_write  out  1  one-cycle write strobe
- mem_write_address  out  32  zero-extended index
- mem_write_value  out  SIZE  write data
- mem_read  out  1  read strobe; memory updates on its level change
- mem_read_address  out  32  zero-extended index
- mem_data  in  SIZE  memory read data, combinational from mem_read

## Operation
- States: IDLE, LOAD, RD_REQ, OUT. idx is an IW-bit counter, reset to 0 on every start.
- IDLE: load_start -> LOAD; otherwise dump_start -> RD_REQ. Load wins if both starts are high in the same cycle. Starts are ignored when busy=1.
- LOAD: in_ready=1. On in_valid&&in_ready:
  - Register mem_write=1, mem_write_address=idx, mem_write_value=in_data for exactly the next cycle.
  - Increment idx. After the handshake for idx=N-1, go to IDLE.
  - The final write strobe is therefore high during the first IDLE cycle.
- RD_REQ: mem_read=1 and mem_read_address=idx for one cycle. At the end of the cycle, capture mem_data into out_data and go to OUT.
- OUT: mem_read=0 and out_valid=1, with out_data held until out_ready.
  - On handshake, if idx=N-1, go to IDLE and clear out_valid.
  - Otherwise increment idx and go to RD_REQ.
- mem_read is never high on two consecutive cycles. The low cycle guarantees a level change for the memory's read trigger.
- in_valid outside LOAD and out_ready outside OUT are ignored.
- Reset sets state IDLE and idx=0. All outputs reset to 0: busy, in_ready, out_valid, out_data, out_last, mem_write, mem_read and both addresses.
- Reset mid-operation aborts immediately. No further strobes are issued, and partially loaded data is not completed.

## Timing
- Load throughput is 1 element/cycle. A write strobe occurs 1 cycle after each input handshake.
- Readback takes at least 2 cycles per element (RD_REQ + OUT). out_valid first rises 2 cycles after the dump_start sample.
- dump_start sampled in the cycle carrying the final write strobe is legal. The first read occurs 1 cycle later and sees the written value.
- Index wrap: idx never exceeds N-1. The N-th handshake terminates the phase instead of wrapping.
- out_last equals out_valid && (idx==N-1).

## Structure
- Shared package or header `mat_mem_pkg` holds:
  - State encoding localparams: IDLE=0, LOAD=1, RD_REQ=2, OUT=3.
  - The default ROW/COLUMN/SIZE shared with the memory and the multiplier.
- No sub-module: a single FSM plus the idx counter.
- The verification top instantiates this block with the matrix memory on the same clk/rst.

## Test plan
- Assert rst for 2 cycles -> every output 0, state IDLE; start pulses during rst ignored.
- load_start, then in_data 5,6,7,8 with continuous in_valid -> mem_write high on 4 consecutive cycles with addresses 0,1,2,3 and values 5,6,7,8; busy falls after the 4th handshake.
- dump_start with out_ready=1 -> out_data 5,6,7,8 one element every 2 cycles; out_last only with 8; mem_read alternates 1,0.
- Dump with out_ready held low 3 cycles on the element at index 1 -> out_valid=1 and out_data=6 stable throughout; no mem_read pulse until the handshake.
- load_start and dump_start in the same cycle -> LOAD entered; a dump_start pulse mid-load has no effect.
- rst after 2 of 4 load handshakes -> next cycle IDLE with all outputs 0. A following dump returns 0,0,0,0, because the shared rst cleared the memory.
